// File: rtl/nes_oam_dma_if.sv
// Sprite-DMA bus bundle: CPU-bus snoop inputs plus the spr requester port of nes_bus.
// The DMA engine connects through the master modport; the bus or arbiter side uses slave.
interface nes_oam_dma_if;
  logic [15:0] i_bus_addr;
  logic [7:0]  i_bus_wdata;
  logic        i_bus_wn;
  logic        o_spr_req;
  logic        i_spr_gnt;
  logic [15:0] o_spr_addr;
  logic        o_spr_wn;
  logic [7:0]  o_spr_wdata;
  logic [7:0]  i_spr_rdata;
  logic        o_busy;

  modport master (
    input  i_bus_addr, i_bus_wdata, i_bus_wn, i_spr_gnt, i_spr_rdata,
    output o_spr_req, o_spr_addr, o_spr_wn, o_spr_wdata, o_busy
  );

  modport slave (
    output i_bus_addr, i_bus_wdata, i_bus_wn, i_spr_gnt, i_spr_rdata,
    input  o_spr_req, o_spr_addr, o_spr_wn, o_spr_wdata, o_busy
  );
endinterface

// File: rtl/nes_oam_dma.sv
// Sprite DMA: a write to TRIG_ADDR copies CPU page $XX00-$XXFF into OAM through OAM_ADDR.
// Define NES_OAM_DMA_ALIGN_EN to add the extra dummy read when HALT completes on an odd cycle.
module nes_oam_dma #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_ADDR  = 16'h2004
) (
  input  logic          i_clk,
  input  logic          i_rst,
  nes_oam_dma_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HALT  = 3'd1;
`ifdef NES_OAM_DMA_ALIGN_EN
  localparam logic [2:0] S_ALIGN = 3'd2;
`endif
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  logic [2:0]  r_state;
  logic [7:0]  r_page;
  logic [7:0]  r_index;
  logic        r_req;
  logic [15:0] r_addr;
  logic        r_wn;
  logic [7:0]  r_wdata;

  logic       w_trig;
  logic       w_last;
  logic [2:0] w_halt_next;

  assign w_trig = !bus.i_bus_wn && (bus.i_bus_addr == TRIG_ADDR);
  assign w_last = (r_index == 8'hFF);

`ifdef NES_OAM_DMA_ALIGN_EN
  // Free-running phase bit standing in for the CPU get/put cycle.
  logic r_parity;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_parity <= 1'b0;
    else       r_parity <= ~r_parity;
  end

  assign w_halt_next = r_parity ? S_ALIGN : S_READ;
`else
  assign w_halt_next = S_READ;
`endif

  // Outputs are loaded together with the state so each beat's bus fields are registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_page  <= 8'h00;
      r_index <= 8'h00;
      r_req   <= 1'b0;
      r_addr  <= 16'h0000;
      r_wn    <= 1'b1;
      r_wdata <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_page  <= bus.i_bus_wdata;
            r_index <= 8'h00;
            r_state <= S_HALT;
            r_req   <= 1'b1;
            r_addr  <= {bus.i_bus_wdata, 8'h00};
            r_wn    <= 1'b1;
          end
        end
        // HALT, ALIGN and the first READ share {page,8'h00}, so the address needs no reload.
        S_HALT: begin
          if (bus.i_spr_gnt) r_state <= w_halt_next;
        end
`ifdef NES_OAM_DMA_ALIGN_EN
        S_ALIGN: begin
          if (bus.i_spr_gnt) r_state <= S_READ;
        end
`endif
        S_READ: begin
          if (bus.i_spr_gnt) begin
            r_wdata <= bus.i_spr_rdata;
            r_state <= S_WRITE;
            r_addr  <= OAM_ADDR;
            r_wn    <= 1'b0;
          end
        end
        S_WRITE: begin
          if (bus.i_spr_gnt) begin
            r_wn <= 1'b1;
            if (w_last) begin
              r_state <= S_IDLE;
              r_req   <= 1'b0;
              r_index <= 8'h00;
              r_addr  <= 16'h0000;
            end else begin
              r_index <= r_index + 8'd1;
              r_addr  <= {r_page, r_index + 8'd1};
              r_state <= S_READ;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_spr_req   = r_req;
  assign bus.o_busy      = r_req;
  assign bus.o_spr_addr  = r_addr;
  assign bus.o_spr_wn    = r_wn;
  assign bus.o_spr_wdata = r_wdata;

endmodule

// File: tb/tb_nes_oam_dma.sv
// Bench for nes_oam_dma: a beat-queue model built from the transfer rules, checked on every cycle.
// Works in both builds; NES_OAM_DMA_ALIGN_EN selects the expected ALIGN behaviour.
module tb_nes_oam_dma;

`ifdef NES_OAM_DMA_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] addr;
    logic        wn;
    logic [7:0]  data;
    logic        halt;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nes_oam_dma_if bus_if ();

  nes_oam_dma dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if.master)
  );

  logic [7:0] mem [0:65535];
  assign bus_if.i_spr_rdata = mem[bus_if.o_spr_addr];

  beat_t      q[$];
  bit         m_par;
  bit         armed = 1'b0;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         req_cycles = 0;
  int         deny_cycles = 0;
  int         align_cnt = 0;
  int         oam_wr = 0;
  logic [7:0] oam [0:255];

  task automatic build(input logic [7:0] p);
    q.push_back(beat_t'{addr: {p, 8'h00}, wn: 1'b1, data: 8'h00, halt: 1'b1});
    for (int i = 0; i < 256; i++) begin
      q.push_back(beat_t'{addr: {p, 8'(i)}, wn: 1'b1, data: 8'h00, halt: 1'b0});
      q.push_back(beat_t'{addr: 16'h2004, wn: 1'b0, data: mem[{p, 8'(i)}], halt: 1'b0});
    end
  endtask

  // Compare the current cycle against the model, then advance the model across the coming edge.
  always @(negedge clk) begin
    logic  ok;
    beat_t h;
    if (armed) begin
      if (q.size() == 0) begin
        ok = (bus_if.o_spr_req === 1'b0) && (bus_if.o_busy === 1'b0);
        h  = beat_t'{addr: 16'h0000, wn: 1'b1, data: 8'h00, halt: 1'b0};
      end else begin
        h  = q[0];
        ok = (bus_if.o_spr_req === 1'b1) && (bus_if.o_busy === 1'b1) &&
             (bus_if.o_spr_addr === h.addr) && (bus_if.o_spr_wn === h.wn) &&
             (h.wn || (bus_if.o_spr_wdata === h.data));
      end
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("FAIL cycle t=%0t got req=%b addr=%h wn=%b wdata=%h required req=%b addr=%h wn=%b wdata=%h",
                 $time, bus_if.o_spr_req, bus_if.o_spr_addr, bus_if.o_spr_wn, bus_if.o_spr_wdata,
                 q.size() != 0, h.addr, h.wn, h.data);
      end
      if (bus_if.o_spr_req === 1'b1) begin
        req_cycles++;
        if (!bus_if.i_spr_gnt) deny_cycles++;
        if (bus_if.i_spr_gnt && !bus_if.o_spr_wn && bus_if.o_spr_addr == 16'h2004) begin
          if (oam_wr < 256) oam[oam_wr] = bus_if.o_spr_wdata;
          oam_wr++;
        end
      end
    end
    if (rst) begin
      q.delete();
      m_par = 1'b0;
      armed = 1'b1;
    end else begin
      if (q.size() == 0) begin
        if (!bus_if.i_bus_wn && bus_if.i_bus_addr == 16'h4014) build(bus_if.i_bus_wdata);
      end else if (bus_if.i_spr_gnt) begin
        h = q.pop_front();
        if (ALIGN && h.halt && m_par) begin
          q.push_front(beat_t'{addr: h.addr, wn: 1'b1, data: 8'h00, halt: 1'b0});
          align_cnt++;
        end
      end
      m_par = ~m_par;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, " req"}, int'(bus_if.o_spr_req), 0);
    check({nm, " busy"}, int'(bus_if.o_busy), 0);
    check({nm, " addr"}, int'(bus_if.o_spr_addr), 0);
    check({nm, " wn"}, int'(bus_if.o_spr_wn), 1);
    check({nm, " wdata"}, int'(bus_if.o_spr_wdata), 0);
  endtask

  // Triggers page p so that the HALT cycle sees parity halt_par.
  task automatic start_xfer(input logic [7:0] p, input bit halt_par);
    if (m_par == halt_par) tick();
    req_cycles  = 0;
    deny_cycles = 0;
    align_cnt   = 0;
    oam_wr      = 0;
    bus_if.i_bus_addr  = 16'h4014;
    bus_if.i_bus_wn    = 1'b0;
    bus_if.i_bus_wdata = p;
    tick();
    bus_if.i_bus_addr  = 16'h0000;
    bus_if.i_bus_wn    = 1'b1;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (bus_if.o_spr_req === 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) check({nm, " timeout"}, 1, 0);
  endtask

  task automatic wait_read(input logic [15:0] a);
    int n;
    n = 0;
    while (!(bus_if.o_spr_addr == a && bus_if.o_spr_wn) && n < 1500) begin
      tick();
      n++;
    end
    if (n >= 1500) check("wait_read timeout", int'(a), -1);
  endtask

  task automatic check_oam(input string nm, input logic [7:0] p);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (oam[i] !== mem[{p, 8'(i)}]) bad++;
    check({nm, " oam bytes wrong"}, bad, 0);
    check({nm, " oam write count"}, oam_wr, 256);
  endtask

  initial begin
    bus_if.i_bus_addr  = 16'h0000;
    bus_if.i_bus_wdata = 8'h00;
    bus_if.i_bus_wn    = 1'b1;
    bus_if.i_spr_gnt   = 1'b1;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Plain copy of page 2, which holds 0..255.
    start_xfer(8'h02, 1'b0);
    wait_done("page2");
    check("page2 req cycles", req_cycles, 513);
    for (int i = 0; i < 256; i++) if (oam[i] !== 8'(i)) check("page2 oam literal", int'(oam[i]), i);
    check("page2 oam write count", oam_wr, 256);

    // HALT completing on parity 1: ALIGN taken only when compiled in.
    start_xfer(8'h02, 1'b1);
    wait_done("parity1");
    check("parity1 req cycles", req_cycles, ALIGN ? 514 : 513);
    check("parity1 align beats", align_cnt, ALIGN ? 1 : 0);
    check_oam("parity1", 8'h02);

    // Grant gaps: 4 cycles in READ of 0x37, 3 cycles in WRITE of 0x80.
    start_xfer(8'h02, 1'b0);
    wait_read(16'h0237);
    bus_if.i_spr_gnt = 1'b0;
    repeat (4) tick();
    bus_if.i_spr_gnt = 1'b1;
    wait_read(16'h0280);
    tick();
    bus_if.i_spr_gnt = 1'b0;
    repeat (3) tick();
    bus_if.i_spr_gnt = 1'b1;
    wait_done("gaps");
    check("gaps req cycles", req_cycles, 520);
    check_oam("gaps", 8'h02);

    // Re-trigger of page 7 mid-transfer must be ignored.
    start_xfer(8'h02, 1'b0);
    wait_read(16'h0240);
    bus_if.i_bus_addr  = 16'h4014;
    bus_if.i_bus_wn    = 1'b0;
    bus_if.i_bus_wdata = 8'h07;
    tick();
    bus_if.i_bus_addr  = 16'h0000;
    bus_if.i_bus_wn    = 1'b1;
    wait_done("retrig");
    check("retrig req cycles", req_cycles, 513);
    check_oam("retrig", 8'h02);

    // Reset mid-transfer, then a fresh copy of page 3.
    start_xfer(8'h02, 1'b0);
    wait_read(16'h0290);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midreset");
    start_xfer(8'h03, 1'b0);
    wait_done("page3");
    check("page3 req cycles", req_cycles, 513);
    check_oam("page3", 8'h03);

    // Non-triggers: write to $4015, read of $4014, reset together with a trigger.
    bus_if.i_bus_addr  = 16'h4015;
    bus_if.i_bus_wn    = 1'b0;
    bus_if.i_bus_wdata = 8'h05;
    tick();
    bus_if.i_bus_addr  = 16'h4014;
    bus_if.i_bus_wn    = 1'b1;
    tick();
    rst = 1'b1;
    bus_if.i_bus_wn = 1'b0;
    tick();
    rst = 1'b0;
    bus_if.i_bus_addr = 16'h0000;
    bus_if.i_bus_wn   = 1'b1;
    repeat (3) tick();
    check("no trigger req", int'(bus_if.o_spr_req), 0);
    check("no trigger busy", int'(bus_if.o_busy), 0);

    // Randomized pages, HALT parity and grant pattern.
    for (int t = 0; t < 3; t++) begin
      logic [7:0] p;
      bit         hp;
      int         n;
      p  = 8'($urandom_range(3, 7));
      hp = 1'($urandom);
      start_xfer(p, hp);
      n = 0;
      while (bus_if.o_spr_req === 1'b1 && n < 5000) begin
        bus_if.i_spr_gnt = ($urandom_range(0, 3) != 0);
        tick();
        n++;
      end
      bus_if.i_spr_gnt = 1'b1;
      if (n >= 5000) check("random timeout", 1, 0);
      check("random req cycles", req_cycles, 513 + (ALIGN && hp ? 1 : 0) + deny_cycles);
      check_oam("random", p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/nes_oam_dma.md
# nes_oam_dma

Sprite-DMA engine for the console's CPU-side bus. It detects a CPU write to $4014 and requests the bus on the `spr` requester port of `nes_bus`. Once granted, it copies 256 bytes from CPU page `$XX00–$XXFF` into the PPU OAM through repeated writes to $2004. It is the controller that drives the currently unconnected `i_spr_*`/`o_spr_gnt` ports. It shares the bus with the CPU and the DMC reader under `nes_bus` arbitration.

## Interface
Parameters:
- `TRIG_ADDR`, default 16'h4014: bus address whose write starts a transfer.
- `OAM_ADDR`, default 16'h2004: PPU OAM data port written on each transfer beat.

Ports:
- `i_clk`  in  1  CPU clock; the block has one clock.
- `i_rst`  in  1  reset, synchronous and active-high.
- `i_bus_addr`  in  16  shared bus address, used for snooping.
- `i_bus_wdata`  in  8  shared bus write data.
- `i_bus_wn`  in  1  shared bus direction: 1 = read, 0 = write.
- `o_spr_req`  out  1  bus request to `nes_bus`.
- `i_spr_gnt`  in  1  bus grant. It may drop at any cycle, for example on a DMC steal.
- `o_spr_addr`  out  16  address driven while granted.
- `o_spr_wn`  out  1  1 = read beat, 0 = write beat.
- `o_spr_wdata`  out  8  byte written to OAM.
- `i_spr_rdata`  in  8  read data. It is valid in the same cycle as the read beat and is sampled at the closing edge.
- `o_busy`  out  1  transfer in progress; equal to `o_spr_req`.

Reset values: `o_spr_req`=0, `o_busy`=0, `o_spr_addr`=16'h0000, `o_spr_wn`=1, `o_spr_wdata`=8'h00. Internal page=0, index=0, parity=0, state=IDLE.

## Operation
- Trigger: on a rising edge where `i_bus_wn`=0 and `i_bus_addr`=TRIG_ADDR in state IDLE:
  - latch page ← `i_bus_wdata`, index ← 0;
  - go to HALT.
- A trigger write while not IDLE is ignored. It has no effect on page or progress.
- A parity bit toggles on every clock after reset, starting at 0. It approximates CPU get/put cycle phase.
- States:
  - IDLE: `o_spr_req`=0.
  - HALT: one dummy read beat, `o_spr_addr`={page,8'h00}, `o_spr_wn`=1. It completes on a cycle with `i_spr_gnt`=1.
    - Next state is ALIGN if the ALIGN feature is compiled in and parity=1 in the completing cycle.
    - Otherwise next state is READ.
  - ALIGN: one dummy read beat with the same address as HALT. It completes when granted; next state is READ.
  - READ: `o_spr_addr`={page,index}, `o_spr_wn`=1. When granted, latch byte ← `i_spr_rdata`; next state is WRITE.
  - WRITE: `o_spr_addr`=OAM_ADDR, `o_spr_wn`=0, `o_spr_wdata`=byte. When granted:
    - if index=8'hFF, next state is IDLE;
    - otherwise index ← index+1 and next state is READ.
- Grant loss: any state other than IDLE holds while `i_spr_gnt`=0.
  - No latch, index change, or state change occurs.
  - Outputs stay stable, and the beat repeats when grant returns.
- Index is 8 bits and the source address never crosses the page: `$XXFF` is the last read. After the final write, index returns to 0.
- Reset mid-transfer: on the next edge with `i_rst`=1, the block goes to IDLE and `o_spr_req` drops.
  - A partial OAM load is abandoned; no resume.
- Simultaneous `i_rst` and trigger: reset wins.

## Timing
- Trigger written in cycle T: `o_spr_req`=1 from cycle T+1.
- With continuous grant:
  - HALT occupies T+1, ALIGN (if taken) T+2, then 256 READ/WRITE pairs.
  - `o_spr_req` is high for 513 cycles, or 514 if aligned.
  - `o_spr_req` is 0 in the cycle after the final WRITE.
- Each denied cycle extends the transfer by exactly one cycle.
- A new trigger is accepted earliest on the first IDLE cycle, i.e. the cycle where `o_spr_req`=0.
- Outputs are registered; no combinational path from `i_spr_gnt` to outputs.

## Configuration
- `NES_OAM_DMA_ALIGN_EN` defined:
  - ALIGN state exists;
  - the transfer is 514 cycles when HALT completes with parity=1, else 513.
- Not defined:
  - ALIGN state and its transitions are removed;
  - every transfer is 513 granted cycles regardless of parity.

## Test plan
- Page 8'h02, RAM $0200–$02FF = i, grant always 1, macro off:
  - 256 writes to $2004 with data 0x00..0xFF in order;
  - `o_spr_req` high exactly 513 cycles.
- Macro on, trigger timed so HALT completes with parity=1 → `o_spr_req` high 514 cycles. Repeat with parity=0 → 513 cycles.
- Drop `i_spr_gnt` for 4 cycles during READ of index 0x37 and 3 cycles during WRITE of index 0x80:
  - address and data held stable during the gaps;
  - no skipped or duplicated OAM write;
  - total 520 cycles with macro off.
- Second $4014 write of 8'h07 at index 0x40 mid-transfer:
  - ignored; remaining reads still from page 0x02.
- Assert `i_rst` at index 0x90:
  - next cycle `o_spr_req`=0 and outputs equal their reset values;
  - a fresh trigger of page 8'h03 then completes a full 256-byte copy from $0300.
- Trigger write to $4015 or a read of $4014 → no request, block stays IDLE.
